// File: rtl/cam_arb_pkg.sv
// Shared types and constants for the camera SDRAM write arbiter.
package cam_arb_pkg;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      BURST = 1'b1
   } arb_state_e;

   localparam logic RQ_LWIR = 1'b0;
   localparam logic RQ_SWIR = 1'b1;

   localparam int MAX_BURST_DEF = 16;

   // A burst length is legal when it is non-zero and no larger than the master allows.
   function automatic logic bc_legal(input int bc, input int max_bc);
      return (bc != 0) && (bc <= max_bc);
   endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way burst arbiter: round-robin on last_grant, or fixed priority to requester 0.
module rr_arbiter2 (
   input  logic [1:0] req,
   input  logic       last_grant,
   input  logic       rr_en,
   output logic [1:0] grant
);

   // one-hot pick among the active requests
   always_comb begin
      grant = 2'b00;
      case (req)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11: begin
            if (rr_en && !last_grant) begin
               grant = 2'b10;
            end else begin
               grant = 2'b01;
            end
         end
         default: grant = 2'b00;
      endcase
   end

endmodule

// File: rtl/cam_sdram_wr_arbiter.sv
// Shares one f2h_sdram Avalon-MM write master between the LWIR (rq0) and SWIR (rq1) capture paths.
module cam_sdram_wr_arbiter
   import cam_arb_pkg::*;
#(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 64,
   parameter int BURST_W   = 5,
   parameter int MAX_BURST = MAX_BURST_DEF,
   parameter int RR_EN     = 1
) (
   input  logic                clk_clk,
   input  logic                reset_reset_n,
   input  logic                enable,
   input  logic                rq0_req,
   input  logic [ADDR_W-1:0]   rq0_addr,
   input  logic [BURST_W-1:0]  rq0_burstcount,
   output logic                rq0_ack,
   output logic                rq0_err,
   input  logic [DATA_W-1:0]   rq0_wdata,
   input  logic                rq0_wvalid,
   output logic                rq0_wready,
   input  logic                rq1_req,
   input  logic [ADDR_W-1:0]   rq1_addr,
   input  logic [BURST_W-1:0]  rq1_burstcount,
   output logic                rq1_ack,
   output logic                rq1_err,
   input  logic [DATA_W-1:0]   rq1_wdata,
   input  logic                rq1_wvalid,
   output logic                rq1_wready,
   output logic [ADDR_W-1:0]   avm_address,
   output logic [BURST_W-1:0]  avm_burstcount,
   output logic                avm_write,
   output logic [DATA_W-1:0]   avm_writedata,
   output logic [DATA_W/8-1:0] avm_byteenable,
   input  logic                avm_waitrequest,
   output logic                busy,
   output logic                grant_id,
   output logic [15:0]         burst_cnt0,
   output logic [15:0]         burst_cnt1
);

   localparam logic [BURST_W-1:0] BC_ONE = BURST_W'(1);

   arb_state_e          state_r;
   logic                last_grant_r;
   logic                grant_id_r;
   logic [ADDR_W-1:0]   addr_r;
   logic [BURST_W-1:0]  bc_r;
   logic [BURST_W-1:0]  rem_r;
   logic [1:0]          ack_r;
   logic [1:0]          err_r;
   logic [15:0]         cnt0_r;
   logic [15:0]         cnt1_r;

   logic [1:0]          cand_s;
   logic [1:0]          gnt_s;
   logic                sel_id_s;
   logic [ADDR_W-1:0]   sel_addr_s;
   logic [BURST_W-1:0]  sel_bc_s;
   logic                sel_legal_s;
   logic                wr_s;
   logic [DATA_W-1:0]   wd_s;
   logic [1:0]          wready_s;
   logic                beat_s;

   // Requests are only considered in IDLE; a request whose ack is on the wire this cycle
   // has already been consumed, so it must not be taken a second time.
   always_comb begin
      if (state_r == IDLE) begin
         cand_s = {rq1_req, rq0_req} & {enable, enable} & ~ack_r;
      end else begin
         cand_s = 2'b00;
      end
      sel_id_s = gnt_s[1];
      if (sel_id_s == RQ_SWIR) begin
         sel_addr_s = rq1_addr;
         sel_bc_s   = rq1_burstcount;
      end else begin
         sel_addr_s = rq0_addr;
         sel_bc_s   = rq0_burstcount;
      end
      sel_legal_s = bc_legal(int'(sel_bc_s), MAX_BURST);
   end

   rr_arbiter2 u_arb (
      .req        (cand_s),
      .last_grant (last_grant_r),
      .rr_en      (RR_EN != 0),
      .grant      (gnt_s)
   );

   // beat path: granted requester drives the master directly while in BURST
   always_comb begin
      wr_s     = 1'b0;
      wd_s     = {DATA_W{1'b0}};
      wready_s = 2'b00;
      if (state_r == BURST) begin
         if (grant_id_r == RQ_SWIR) begin
            wr_s     = rq1_wvalid;
            wd_s     = rq1_wdata;
            wready_s = {!avm_waitrequest, 1'b0};
         end else begin
            wr_s     = rq0_wvalid;
            wd_s     = rq0_wdata;
            wready_s = {1'b0, !avm_waitrequest};
         end
      end else begin
         wr_s     = 1'b0;
         wd_s     = {DATA_W{1'b0}};
         wready_s = 2'b00;
      end
      beat_s = wr_s & !avm_waitrequest;
   end

   // FSM, burst latch, beat countdown and completion counters
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         state_r      <= IDLE;
         last_grant_r <= 1'b1;
         grant_id_r   <= 1'b0;
         addr_r       <= {ADDR_W{1'b0}};
         bc_r         <= {BURST_W{1'b0}};
         rem_r        <= {BURST_W{1'b0}};
         ack_r        <= 2'b00;
         err_r        <= 2'b00;
         cnt0_r       <= 16'd0;
         cnt1_r       <= 16'd0;
      end else begin
         ack_r <= 2'b00;
         err_r <= 2'b00;
         case (state_r)
            IDLE: begin
               if (|gnt_s) begin
                  ack_r <= gnt_s;
                  if (sel_legal_s) begin
                     addr_r     <= sel_addr_s;
                     bc_r       <= sel_bc_s;
                     rem_r      <= sel_bc_s;
                     grant_id_r <= sel_id_s;
                     state_r    <= BURST;
                  end else begin
                     err_r <= gnt_s;
                  end
               end
            end
            BURST: begin
               if (beat_s) begin
                  rem_r <= rem_r - BC_ONE;
                  if (rem_r == BC_ONE) begin
                     state_r      <= IDLE;
                     last_grant_r <= grant_id_r;
                     if (grant_id_r == RQ_SWIR) begin
                        cnt1_r <= cnt1_r + 16'd1;
                     end else begin
                        cnt0_r <= cnt0_r + 16'd1;
                     end
                  end
               end
            end
            default: state_r <= IDLE;
         endcase
      end
   end

   assign rq0_ack        = ack_r[0];
   assign rq1_ack        = ack_r[1];
   assign rq0_err        = err_r[0];
   assign rq1_err        = err_r[1];
   assign rq0_wready     = wready_s[0];
   assign rq1_wready     = wready_s[1];
   assign avm_address    = addr_r;
   assign avm_burstcount = bc_r;
   assign avm_write      = wr_s;
   assign avm_writedata  = wd_s;
   assign avm_byteenable = {(DATA_W/8){1'b1}};
   assign busy           = (state_r == BURST);
   assign grant_id       = grant_id_r;
   assign burst_cnt0     = cnt0_r;
   assign burst_cnt1     = cnt1_r;

endmodule
